if_id_stage: RTL

Fetch-side pipeline stage directly downstream of the IF next-PC mux. Holds the architectural fetch PC, drives the synchronous instruction memory, produces the sequential PC+4 that the IF mux selects against the branch target, and delivers fetched instructions to decode through the IF/ID pipeline register. Handles decode stalls and branch flushes without losing or duplicating instructions.

---
 rtl/risc_toy_pkg.sv | 31 +++
 rtl/fetch_skid_buf.sv | 59 +++++
 rtl/if_id_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/risc_toy_pkg.sv
// risc_toy_pkg: shared definitions for the toy RISC fetch front end.
//   XLEN         - PC / instruction width
//   PC_RESET_DEF - default fetch PC after reset
//   PC_INC       - sequential PC increment (one 32-bit instruction)
//   fetch_state_e- fetch FSM states {FS_RUN, FS_HOLD}
//   ifid_t       - IF/ID pipeline register bundle {pc, pc4, inst, valid}
//   pc_add4()    - modulo-2^XLEN sequential PC helper
package risc_toy_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HOLD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
    logic            valid;
  } ifid_t;

  // Wraps naturally: 32'hFFFF_FFFC + 4 = 0.
  function automatic logic [XLEN-1:0] pc_add4(input logic [XLEN-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: single-entry capture/drain buffer for one in-flight
// instruction-memory response that arrives while decode is stalled.
//   clk, rstn      - clock, synchronous active-low reset (clears occupancy)
//   clr            - discard the entry (branch flush)
//   cap            - capture {cap_pc, cap_inst}
//   drain          - entry consumed this cycle
//   full           - entry holds a real instruction
//   pc, inst       - stored entry
// Only the occupancy bit is reset; the payload is meaningful only when full.
module fetch_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         cap,
  input  logic         drain,
  input  logic [W-1:0] cap_pc,
  input  logic [W-1:0] cap_inst,
  output logic         full,
  output logic [W-1:0] pc,
  output logic [W-1:0] inst
);

  logic         full_q, full_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] inst_q, inst_d;

  always_comb begin
    full_d = full_q;
    pc_d   = pc_q;
    inst_d = inst_q;
    if (clr || drain) begin
      full_d = 1'b0;
    end else if (cap) begin
      full_d = 1'b1;
      pc_d   = cap_pc;
      inst_d = cap_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    inst_q <= inst_d;
  end

  assign full = full_q;
  assign pc   = pc_q;
  assign inst = inst_q;

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: fetch PC register, synchronous I-memory request, and IF/ID
// pipeline register with stall and branch-flush handling.
//   CLK, RSTN   - clock, synchronous active-low reset
//   PC_IN       - next fetch PC from the IF mux (branch target or PC_NEXT)
//   STALL       - hold IF/ID and fetch PC
//   FLUSH       - branch taken; squash wrong-path fetches (dominates STALL)
//   IMEM_DATA   - instruction, valid the cycle after IMEM_ADDR/IMEM_REQ
//   PC_NEXT     - pc_q + 4
//   IMEM_ADDR   - pc_q
//   IMEM_REQ    - fetch issued this cycle
//   IFID_PC/PC4/INST/VALID - decode-stage instruction
// Build option FETCH_SKID_EN: when defined, a response arriving as a stall
// begins is parked in fetch_skid_buf and delivered first on release (no
// bubble). When undefined, that response is dropped and the fetch PC is
// rewound to refetch it, costing one bubble after release.
// The IF/ID bundle type is sized by risc_toy_pkg::XLEN; keep XLEN equal to it.
module if_id_stage
  import risc_toy_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic [XLEN-1:0] PC_IN,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic [XLEN-1:0] IMEM_DATA,
  output logic [XLEN-1:0] PC_NEXT,
  output logic [XLEN-1:0] IMEM_ADDR,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IFID_PC,
  output logic [XLEN-1:0] IFID_PC4,
  output logic [XLEN-1:0] IFID_INST,
  output logic            IFID_VALID
);

`ifdef FETCH_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tag_pc_q, tag_pc_d;
  logic            tag_vld_q, tag_vld_d;
  ifid_t           ifid_q, ifid_d;
  fetch_state_e    state_q, state_d;

  logic            advance;
  logic            hold_entry;
  logic            skid_full;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_inst;

  assign advance  = ~STALL & ~FLUSH;
  assign IMEM_REQ = RSTN & advance;

  // The only cycle an outstanding response can be pending under a stall is
  // the first one (no request is issued while stalled), i.e. while the FSM
  // is still in RUN. That is where it is parked or rewound.
  assign hold_entry = STALL & ~FLUSH & (state_q == FS_RUN) & tag_vld_q;

`ifdef FETCH_SKID_EN
  fetch_skid_buf #(
    .W (XLEN)
  ) u_skid (
    .clk      (CLK),
    .rstn     (RSTN),
    .clr      (FLUSH),
    .cap      (hold_entry),
    .drain    (advance & skid_full),
    .cap_pc   (tag_pc_q),
    .cap_inst (IMEM_DATA),
    .full     (skid_full),
    .pc       (skid_pc),
    .inst     (skid_inst)
  );
`else
  assign skid_full = 1'b0;
  assign skid_pc   = '0;
  assign skid_inst = '0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tag_pc_d  = tag_pc_q;
    tag_vld_d = tag_vld_q;
    ifid_d    = ifid_q;

    case (state_q)
      FS_RUN:  if (STALL && !FLUSH) state_d = FS_HOLD;
      FS_HOLD: if (!STALL || FLUSH) state_d = FS_RUN;
      default: state_d = FS_RUN;
    endcase

    if (FLUSH) begin
      pc_d         = PC_IN;
      tag_vld_d    = 1'b0;
      ifid_d.valid = 1'b0;
      ifid_d.inst  = '0;
    end else if (STALL) begin
      if (hold_entry) begin
        tag_vld_d = 1'b0;
        // Without a skid entry the response is lost; refetch it on release.
        if (!SKID_EN) pc_d = tag_pc_q;
      end
    end else begin
      pc_d      = PC_IN;
      tag_pc_d  = pc_q;
      tag_vld_d = IMEM_REQ;
      if (skid_full) begin
        ifid_d.pc    = skid_pc;
        ifid_d.pc4   = pc_add4(skid_pc);
        ifid_d.inst  = skid_inst;
        ifid_d.valid = 1'b1;
      end else begin
        ifid_d.pc    = tag_pc_q;
        ifid_d.pc4   = pc_add4(tag_pc_q);
        ifid_d.inst  = IMEM_DATA;
        ifid_d.valid = tag_vld_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= FS_RUN;
      pc_q         <= PC_RESET;
      tag_vld_q    <= 1'b0;
      ifid_q.pc    <= '0;
      ifid_q.pc4   <= PC_INC;
      ifid_q.inst  <= '0;
      ifid_q.valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tag_vld_q <= tag_vld_d;
      ifid_q    <= ifid_d;
    end
  end

  // Tag PC is payload only; tag_vld qualifies it.
  always_ff @(posedge CLK) begin
    tag_pc_q <= tag_pc_d;
  end

  assign PC_NEXT    = pc_add4(pc_q);
  assign IMEM_ADDR  = pc_q;
  assign IFID_PC    = ifid_q.pc;
  assign IFID_PC4   = ifid_q.pc4;
  assign IFID_INST  = ifid_q.inst;
  assign IFID_VALID = ifid_q.valid;

endmodule
